counter_half_down: RTL

//   Half-subtractor based down-counter / countdown timer; the decrementing

---
 rtl/counter_half_down.sv | 90 +++++++++
 1 files changed

// File: rtl/counter_half_down.sv
// Down-counter / countdown timer built on a half-subtractor borrow chain.
// Flags terminal count (done) and wrap below zero (underflow); optional auto-reload.
module counter_half_down #(
   parameter int WIDTH       = 8,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] loadval,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic             underflow
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] reload_reg, reload_next;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] diff;
   logic [WIDTH:0]   borrow;
   logic             done_next, underflow_next;
   logic             terminal;

   // Ripple borrow: en enters at bit 0, borrow[WIDTH] is the wrap below zero.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no latch can be inferred.
      diff      = '0;
      borrow    = '0;
      borrow[0] = en;
      for (int i = 0; i < WIDTH; i++) begin
         diff[i]       = count[i] ^ borrow[i];
         borrow[i + 1] = ~count[i] & borrow[i];
      end
   end

   assign terminal = (state == RUN) && en && (count == WIDTH'(1));

   always_comb begin
      state_next     = state;
      count_next     = count;
      reload_next    = reload_reg;
      done_next      = 1'b0;
      underflow_next = 1'b0;
      if (load) begin
         count_next  = loadval;
         reload_next = loadval;
         state_next  = (loadval != '0) ? RUN : IDLE;
      end else if (en) begin
         count_next     = diff;
         underflow_next = borrow[WIDTH];
         if (terminal) begin
            done_next = 1'b1;
            if (AUTO_RELOAD) begin
               count_next = reload_reg;
            end else begin
               state_next = IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         reload_reg <= '0;
         done       <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         // NOTE: non-blocking so all registers update together from pre-edge values.
         state      <= state_next;
         count      <= count_next;
         reload_reg <= reload_next;
         done       <= done_next;
         underflow  <= underflow_next;
      end
   end

   assign busy = (state == RUN);
   assign zero = (count == '0);

endmodule
